uart_rx_sequencer: RTL

Controller that owns one `UartRx` receiver and sequences its ready/ack handshake. It captures each received byte into a small FIFO, so the receiver is acknowledged promptly and bytes are not dropped while the consumer is busy. It holds the receiver's baud divider and parity configuration and applies changes by resetting the receiver. It sits between `UartRx` and the byte consumer (CPU register block or packet parser).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_byte_fifo.sv | 52 +++++
 rtl/uart_rx_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_RESET,
    CAPTURE,
    ACK,
    WAIT_CLEAR
  } rx_state_e;

  localparam int RX_RESET_CYCLES  = 2;
  localparam int DROP_COUNT_WIDTH = 8;

  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(input logic [DROP_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered storage; head is read straight from storage so a pop
// exposes the next entry on the same edge.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      push_i,
  input  logic [7:0]                data_i,
  input  logic                      pop_i,
  output logic [7:0]                data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_push;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i & ~empty_o;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign w_push  = push_i & (~full_o | w_pop);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Owns one UartRx: sequences its ready/ack handshake, buffers bytes in a FIFO,
// holds its config and restarts it on every config write.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVIDER = 16'd2
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            cfg_write_i,
  input  logic [15:0]                     cfg_divider_i,
  input  logic                            cfg_parity_bit_i,
  input  logic                            cfg_parity_even_i,
  output logic [15:0]                     rx_clock_divider_o,
  output logic                            rx_parity_bit_o,
  output logic                            rx_parity_even_o,
  output logic                            rx_reset_o,
  output logic                            rx_ack_o,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_ready_i,
  output logic [7:0]                      data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            overrun_o,
  input  logic                            overrun_clear_i,
  output logic [DROP_COUNT_WIDTH-1:0]     drop_count_o
);
  localparam int RST_CW = (RX_RESET_CYCLES > 2) ? $clog2(RX_RESET_CYCLES) : 1;

  rx_state_e             r_state;
  logic [RST_CW-1:0]     r_rst_cnt;
  logic                  r_rx_reset, r_rx_ack;
  logic [15:0]           r_divider;
  logic                  r_par_bit, r_par_even;
  logic                  r_overrun;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_cnt;
  logic                  w_full, w_empty, w_pop, w_capture, w_push, w_drop;

  // A config write discards whatever the receiver is presenting this cycle.
  assign w_capture = (r_state == CAPTURE) & rx_ready_i & ~cfg_write_i;
  assign w_pop     = ~w_empty & ready_i;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .data_i  (rx_data_i),
    .pop_i   (w_pop),
    .data_o  (data_o),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= RX_RESET;
      r_rst_cnt  <= '0;
      r_rx_reset <= 1'b1;
      r_rx_ack   <= 1'b0;
      r_divider  <= DEFAULT_DIVIDER;
      r_par_bit  <= 1'b0;
      r_par_even <= 1'b0;
    end else if (cfg_write_i) begin
      r_divider  <= cfg_divider_i;
      r_par_bit  <= cfg_parity_bit_i;
      r_par_even <= cfg_parity_even_i;
      r_state    <= RX_RESET;
      r_rst_cnt  <= '0;
      r_rx_reset <= 1'b1;
      r_rx_ack   <= 1'b0;
    end else begin
      case (r_state)
        RX_RESET: begin
          if (r_rst_cnt == RST_CW'(RX_RESET_CYCLES - 1)) begin
            r_state    <= CAPTURE;
            r_rx_reset <= 1'b0;
          end else begin
            r_rst_cnt  <= r_rst_cnt + 1'b1;
          end
        end
        CAPTURE: if (rx_ready_i) begin
          r_state  <= ACK;
          r_rx_ack <= 1'b1;
        end
        ACK: begin
          r_state  <= WAIT_CLEAR;
          r_rx_ack <= 1'b0;
        end
        WAIT_CLEAR: if (!rx_ready_i) r_state <= CAPTURE;
        default: begin
          r_state    <= RX_RESET;
          r_rst_cnt  <= '0;
          r_rx_reset <= 1'b1;
          r_rx_ack   <= 1'b0;
        end
      endcase
    end
  end

  // A drop coinciding with a clear leaves exactly one drop recorded.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overrun  <= 1'b1;
      r_drop_cnt <= overrun_clear_i ? DROP_COUNT_WIDTH'(1) : sat_inc(r_drop_cnt);
    end else if (overrun_clear_i) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign rx_clock_divider_o = r_divider;
  assign rx_parity_bit_o    = r_par_bit;
  assign rx_parity_even_o   = r_par_even;
  assign rx_reset_o         = r_rx_reset;
  assign rx_ack_o           = r_rx_ack;
  assign valid_o            = ~w_empty;
  assign overrun_o          = r_overrun;
  assign drop_count_o       = r_drop_cnt;

endmodule
